// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and width helpers for the multiplexed 7-segment scan controller.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      PH_BLANK,
      PH_DRIVE,
      PH_DARK
   } slot_phase_e;

   // A single-digit build still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_lut.sv
// Hex nibble to 7-segment pattern, negative logic, bit 0 = segment a.
module seg7_lut (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b1111111;
      case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0011000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode display scanner with frame-aligned word commit,
// per-slot dead-time and optional leading-zero blanking.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 1000,
   parameter int DEAD       = 8
) (
   input  logic                    iCLK,
   input  logic                    iRST_N,
   input  logic [4*NUM_DIGITS-1:0] iDATA,
   input  logic [NUM_DIGITS-1:0]   iMASK,
   input  logic                    iVALID,
   output logic                    oREADY,
   input  logic                    iLZB,
   output logic [6:0]              oSEG,
   output logic [NUM_DIGITS-1:0]   oAN,
   output logic                    oFRAME
);

   localparam int CNT_W  = $clog2(DIV);
   localparam int IDX_W  = idx_width(NUM_DIGITS);
   localparam int DATA_W = 4 * NUM_DIGITS;

   localparam logic [NUM_DIGITS-1:0] AN_OFF   = '1;
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0]      CNT_DEAD = CNT_W'(DEAD);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_W-1:0]     pend_data_q, pend_data_d;
   logic [NUM_DIGITS-1:0] pend_mask_q, pend_mask_d;
   logic                  pend_full_q, pend_full_d;
   logic [DATA_W-1:0]     disp_data_q, disp_data_d;
   logic [NUM_DIGITS-1:0] disp_mask_q, disp_mask_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   logic                  slot_end;
   logic                  frame_wrap;
   logic                  accept;
   logic [NUM_DIGITS-1:0] nz_upper;
   logic [3:0]            nib_sel;
   logic                  digit_on;
   logic [6:0]            lut_seg;
   slot_phase_e           phase;

   always_comb begin
      slot_end   = (cnt_q == CNT_LAST);
      frame_wrap = slot_end && (idx_q == IDX_LAST);
      cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
      idx_d      = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // A word accepted on the wrap cycle itself waits for the following wrap.
   always_comb begin
      accept      = iVALID & ~pend_full_q;
      pend_data_d = pend_data_q;
      pend_mask_d = pend_mask_q;
      pend_full_d = pend_full_q;
      disp_data_d = disp_data_q;
      disp_mask_d = disp_mask_q;
      if (frame_wrap && pend_full_q) begin
         disp_data_d = pend_data_q;
         disp_mask_d = pend_mask_q;
         pend_full_d = 1'b0;
      end else if (accept) begin
         pend_data_d = iDATA;
         pend_mask_d = iMASK;
         pend_full_d = 1'b1;
      end
   end

   // nz_upper[i] is set when any nibble from i up to the top digit is non-zero.
   always_comb begin
      nz_upper                 = '0;
      nz_upper[NUM_DIGITS-1]   = |disp_data_q[DATA_W-1 -: 4];
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
         nz_upper[i] = nz_upper[i+1] | (|disp_data_q[i*4 +: 4]);
      end
   end

   always_comb begin
      nib_sel  = '0;
      digit_on = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_sel  = disp_data_q[i*4 +: 4];
            digit_on = disp_mask_q[i] & ~(iLZB & (i != 0) & ~nz_upper[i]);
         end
      end
   end

   seg7_lut u_lut (
      .nibble (nib_sel),
      .seg    (lut_seg)
   );

   always_comb begin
      if (cnt_q < CNT_DEAD) begin
         phase = PH_BLANK;
      end else if (digit_on) begin
         phase = PH_DRIVE;
      end else begin
         phase = PH_DARK;
      end
      seg_d = (phase == PH_DRIVE) ? lut_seg : SEG_BLANK;
      an_d  = AN_OFF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_d[i] = ~((phase == PH_DRIVE) && (idx_q == IDX_W'(i)));
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         pend_data_q <= '0;
         pend_mask_q <= '0;
         pend_full_q <= 1'b0;
         disp_data_q <= '0;
         disp_mask_q <= '0;
         seg_q       <= SEG_BLANK;
         an_q        <= AN_OFF;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         pend_data_q <= pend_data_d;
         pend_mask_q <= pend_mask_d;
         pend_full_q <= pend_full_d;
         disp_data_q <= disp_data_d;
         disp_mask_q <= disp_mask_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign oSEG   = seg_q;
   assign oAN    = an_q;
   assign oREADY = ~pend_full_q;
   assign oFRAME = frame_wrap;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 4-cycle slots, dead-time 1 (and 2 on a twin).
module tb_seg7_scan_ctrl;

   logic        iCLK;
   logic        iRST_N;
   logic [15:0] iDATA;
   logic [3:0]  iMASK;
   logic        iVALID;
   logic        iLZB;
   logic        oREADY;
   logic [6:0]  oSEG;
   logic [3:0]  oAN;
   logic        oFRAME;
   logic        rdy2;
   logic [6:0]  seg2;
   logic [3:0]  an2;
   logic        frm2;

   int n_tests = 0;
   int n_fail  = 0;

   seg7_scan_ctrl #(.NUM_DIGITS(4), .DIV(4), .DEAD(1)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iMASK(iMASK), .iVALID(iVALID),
      .oREADY(oREADY), .iLZB(iLZB), .oSEG(oSEG), .oAN(oAN), .oFRAME(oFRAME)
   );

   seg7_scan_ctrl #(.NUM_DIGITS(4), .DIV(4), .DEAD(2)) dut2 (
      .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iMASK(iMASK), .iVALID(iVALID),
      .oREADY(rdy2), .iLZB(iLZB), .oSEG(seg2), .oAN(an2), .oFRAME(frm2)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic wait_frame(input string tag);
      int n = 0;
      while (!oFRAME && n < 100) begin
         @(negedge iCLK);
         n++;
      end
      check({tag, "_wrap_to"}, {15'h0, oFRAME}, 16'h1);
   endtask

   task automatic send(input logic [15:0] d, input logic [3:0] m);
      int n = 0;
      iDATA  = d;
      iMASK  = m;
      iVALID = 1'b1;
      while (!oREADY && n < 100) begin
         @(negedge iCLK);
         n++;
      end
      check("send_rdy_to", {15'h0, oREADY}, 16'h1);
      @(posedge iCLK);
      #1 iVALID = 1'b0;
      @(negedge iCLK);
      check("rdy_drop", {15'h0, oREADY}, 16'h0);
   endtask

   // Entered at the negedge just after the committing wrap (chain=1) or waits for it.
   // Slot s position p appears at negedge 4*s+p; the next wrap shows at position 14.
   task automatic check_frame(input string tag, input logic [15:0] data, input logic [3:0] mask,
                              input logic lzb, input bit chain);
      int s;
      int p;
      bit vis;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      if (!chain) begin
         wait_frame(tag);
         @(negedge iCLK);
      end
      for (int j = 0; j < 16; j++) begin
         @(negedge iCLK);
         s = j / 4;
         p = j % 4;
         vis = mask[s] && !(lzb && s > 0 && (data >> (4 * s)) == 16'h0);
         exp_an  = 4'hF;
         exp_seg = 7'h7F;
         if (vis) begin
            exp_an[s] = 1'b0;
            exp_seg   = seg_of(data[4*s +: 4]);
         end
         check($sformatf("%s_an_%0d", tag, j),   {12'h0, oAN},  (p >= 1) ? {12'h0, exp_an} : 16'hF);
         check($sformatf("%s_seg_%0d", tag, j),  {9'h0, oSEG},  (p >= 1) ? {9'h0, exp_seg} : 16'h7F);
         check($sformatf("%s_an2_%0d", tag, j),  {12'h0, an2},  (p >= 2) ? {12'h0, exp_an} : 16'hF);
         check($sformatf("%s_seg2_%0d", tag, j), {9'h0, seg2},  (p >= 2) ? {9'h0, exp_seg} : 16'h7F);
         check($sformatf("%s_frm_%0d", tag, j),  {15'h0, oFRAME}, (j == 14) ? 16'h1 : 16'h0);
         check($sformatf("%s_frm2_%0d", tag, j), {15'h0, frm2},   (j == 14) ? 16'h1 : 16'h0);
      end
   endtask

   initial begin
      int dark_bad;
      int first_frm;
      iRST_N = 1'b0;
      iDATA  = '0;
      iMASK  = '0;
      iVALID = 1'b0;
      iLZB   = 1'b0;
      repeat (3) @(negedge iCLK);
      check("rst_seg",   {9'h0, oSEG},    16'h7F);
      check("rst_an",    {12'h0, oAN},    16'hF);
      check("rst_rdy",   {15'h0, oREADY}, 16'h1);
      check("rst_rdy2",  {15'h0, rdy2},   16'h1);
      check("rst_frame", {15'h0, oFRAME}, 16'h0);
      iRST_N = 1'b1;

      send(16'h12A0, 4'hF);
      check_frame("digits", 16'h12A0, 4'hF, 1'b0, 1'b0);

      iLZB = 1'b1;
      send(16'h0005, 4'hF);
      check_frame("lzb_on", 16'h0005, 4'hF, 1'b1, 1'b0);
      iLZB = 1'b0;
      check_frame("lzb_off", 16'h0005, 4'hF, 1'b0, 1'b1);

      send(16'h3210, 4'b0101);
      check_frame("mask", 16'h3210, 4'b0101, 1'b0, 1'b0);

      send(16'hBEEF, 4'hF);
      iDATA  = 16'h4C07;
      iMASK  = 4'hF;
      iVALID = 1'b1;
      wait_frame("b2b");
      check("b2b_rdy_at_wrap", {15'h0, oREADY}, 16'h0);
      @(negedge iCLK);
      check("b2b_rdy_after_wrap", {15'h0, oREADY}, 16'h1);
      @(posedge iCLK);
      #1 iVALID = 1'b0;
      check_frame("b2b_first", 16'hBEEF, 4'hF, 1'b0, 1'b1);
      check("b2b_rdy_second", {15'h0, oREADY}, 16'h1);
      check_frame("b2b_second", 16'h4C07, 4'hF, 1'b0, 1'b1);

      send(16'h9999, 4'hF);
      #2 iRST_N = 1'b0;
      #1;
      check("mid_rst_seg",   {9'h0, oSEG},    16'h7F);
      check("mid_rst_an",    {12'h0, oAN},    16'hF);
      check("mid_rst_rdy",   {15'h0, oREADY}, 16'h1);
      check("mid_rst_frame", {15'h0, oFRAME}, 16'h0);
      @(negedge iCLK);
      iRST_N    = 1'b1;
      dark_bad  = 0;
      first_frm = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge iCLK);
         if (oAN != 4'hF || oSEG != 7'h7F) dark_bad++;
         if (oFRAME && first_frm < 0) first_frm = k;
      end
      check("post_rst_dark", dark_bad[15:0], 16'h0);
      check("post_rst_first_wrap", first_frm[15:0], 16'd15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
